// File: rtl/sevenseg_scan8_if.sv
// sevenseg_scan8_if -- bundle between the clock core and the display scanner.
//   master : clock core side, drives the time digits and display flags,
//            observes the pin outputs
//   slave  : the scanner, consumes digits/flags and drives the board pins
// Signals:
//   fmt          1 = 12-hour display, 0 = 24-hour
//   ampm         1 = PM (only shown when fmt=1)
//   hrL..milM    BCD digits, left to right on the display
//   blink_mask   bit i=1 blinks display position i
//   an           anode enables, active-low, an[7] = leftmost
//   seg          {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
interface sevenseg_scan8_if;
  logic       fmt;
  logic       ampm;
  logic [3:0] hrL, hrR, mL, mR, sL, sR, milL, milM;
  logic [7:0] blink_mask;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output fmt, ampm, hrL, hrR, mL, mR, sL, sR, milL, milM, blink_mask,
    input  an, seg, dp
  );

  modport slave (
    input  fmt, ampm, hrL, hrR, mL, mR, sL, sR, milL, milM, blink_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/sevenseg_scan8.sv
// sevenseg_scan8 -- 8-digit common-anode seven-segment scanner.
// Time-multiplexes the clock core's BCD digits onto the display, one digit
// per slot of SCAN_DIV cycles, with an all-dark guard window at the start of
// every slot, HH.MM.SS.ms separator dots, a PM dot on the rightmost digit,
// leading-zero blanking of the tens-of-hours digit in 12-hour mode and
// per-position blink driven by a free-running slot counter.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  sevenseg_scan8_if.slave (digits/flags in, an/seg/dp out)
// Parameters:
//   SCAN_DIV   clk cycles per digit slot
//   BLANK_CYC  cycles of all-anodes-off at slot start; keep below SCAN_DIV
//   BLINK_DIV  digit slots per blink half-period

// Active-low BCD to seven-segment decode; non-decimal codes go dark.
module sevenseg_scan8_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module sevenseg_scan8 #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 4,
  parameter int BLINK_DIV = 500
) (
  input  logic              clk,
  input  logic              rst,
  sevenseg_scan8_if.slave   bus
);
  localparam int NUM_POS = 8;
  localparam int DW = $clog2(SCAN_DIV  > 1 ? SCAN_DIV  : 2);
  localparam int BW = $clog2(BLINK_DIV > 1 ? BLINK_DIV : 2);

  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  // Display order: [7] is the leftmost position.
  logic [NUM_POS-1:0][3:0] digs;
  logic [3:0]    cur_dig;
  logic [6:0]    seg_nxt;
  logic [7:0]    an_nxt;
  logic          dp_nxt;
  logic          slot_end;
  logic          blink_end;
  logic          slot_blank;
  logic          blink_off;
  logic          lz_off;
  logic          dark;

  assign digs = {bus.hrL, bus.hrR, bus.mL, bus.mR,
                 bus.sL,  bus.sR,  bus.milL, bus.milM};
  assign cur_dig = digs[idx];

  assign slot_end  = (div_cnt == DW'(SCAN_DIV - 1));
  assign blink_end = (blink_cnt == BW'(BLINK_DIV - 1));

  // Guard window keeps the previous digit's segments from ghosting onto the
  // newly selected anode while the segment lines settle.
  assign slot_blank = (div_cnt < DW'(BLANK_CYC));
  assign blink_off  = bus.blink_mask[idx] & blink_ph;
  // "07:15" in 12-hour mode reads as " 7:15".
  assign lz_off     = (idx == 3'd7) & bus.fmt & (bus.hrL == 4'd0);
  assign dark       = slot_blank | blink_off | lz_off;

  sevenseg_scan8_dec u_dec (
    .bcd (cur_dig),
    .seg (seg_nxt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_POS; gi++) begin : g_an
      assign an_nxt[gi] = dark | (idx != 3'(gi));
    end
  endgenerate

  // Separators follow the HH, MM and SS pairs; the rightmost dot flags PM.
  assign dp_nxt = ~((idx == 3'd6) | (idx == 3'd4) | (idx == 3'd2) |
                    ((idx == 3'd0) & bus.fmt & bus.ampm));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= 3'd7;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
      if (slot_end) begin
        div_cnt <= '0;
        idx     <= idx - 3'd1;
        // Blink phase advances on slot count only, so it never jitters with
        // digit or mask changes.
        if (blink_end) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
endmodule
